// File: rtl/pwm_ramp_sequencer.sv
// Multi-channel PWM sequencer: shared period counter, shadowed PERIOD, per-channel duty ramp.
// Optional ramp-complete interrupt and CTRL irq_mask bit enabled by defining PWM_RAMP_IRQ_EN.
module pwm_ramp_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [3:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              cfg_rvalid,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick,
  output logic              busy
`ifdef PWM_RAMP_IRQ_EN
  ,
  output logic              ramp_irq
`endif
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_P     = CNT_W'(DEFAULT_PERIOD);
  localparam logic [3:0]       A_CTRL    = 4'd0;
  localparam logic [3:0]       A_PERIOD  = 4'd1;
  localparam logic [3:0]       A_STEP    = 4'd2;
  localparam int               TGT_BASE  = 3;
  localparam int               DUTY_BASE = 3 + NUM_CH;

  logic                    r_enable;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_period_act;
  logic [CNT_W-1:0]        r_period_shd;
  logic [CNT_W-1:0]        r_step;
  logic [CNT_W-1:0]        r_duty   [NUM_CH];
  logic [CNT_W-1:0]        r_target [NUM_CH];
  logic [NUM_CH-1:0]       r_pwm_p1;
  logic                    r_tick_p1;
  logic                    r_busy_p1;
  logic                    r_rvalid_p1;
  logic [31:0]             r_rdata_p1;
`ifdef PWM_RAMP_IRQ_EN
  logic                    r_irq_mask;
  logic                    r_busy_p2;
  logic                    r_irq_p2;
`endif

  logic                    w_wrap;
  logic                    w_wr_ctrl;
  logic                    w_en_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [CNT_W-1:0]        w_pact_nxt;
  logic                    w_busy_any;
  logic [31:0]             w_rdata;
  logic                    w_unused;

  // Step cur toward tgt by stp in CNT_W+1 bits so neither direction can wrap.
  function automatic logic [CNT_W-1:0] ramp_toward(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt,
                                                   input logic [CNT_W-1:0] stp);
    logic [CNT_W:0] cur_x, tgt_x, stp_x, sum_x, dif_x;
    cur_x = {1'b0, cur};
    tgt_x = {1'b0, tgt};
    stp_x = {1'b0, stp};
    sum_x = cur_x + stp_x;
    dif_x = cur_x - stp_x;
    ramp_toward = cur;
    if (stp == '0)      ramp_toward = tgt;
    else if (cur < tgt) ramp_toward = (sum_x > tgt_x) ? tgt : sum_x[CNT_W-1:0];
    else if (cur > tgt) ramp_toward = (cur_x < tgt_x + stp_x) ? tgt : dif_x[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] v);
    return (v < TWO) ? TWO : v;
  endfunction

  assign w_unused = &{1'b0, cfg_wdata[31:CNT_W]};

  always_comb begin
    w_wrap     = r_enable && (r_cnt == r_period_act - ONE);
    w_wr_ctrl  = cfg_we && (cfg_addr == A_CTRL);
    w_en_nxt   = w_wr_ctrl ? cfg_wdata[0] : r_enable;
    w_cnt_nxt  = (!r_enable || w_wrap) ? '0 : r_cnt + ONE;
    w_pact_nxt = (!r_enable || w_wrap) ? r_period_shd : r_period_act;
    w_busy_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_duty[i] != r_target[i]) w_busy_any = 1'b1;
    end
  end

  // Read mux sees pre-edge state, so a same-cycle write is not yet visible.
  always_comb begin
    w_rdata = '0;
    if (cfg_addr == A_CTRL) begin
      w_rdata[1:0] = {r_busy_p1, r_enable};
`ifdef PWM_RAMP_IRQ_EN
      w_rdata[2]   = r_irq_mask;
`endif
    end else if (cfg_addr == A_PERIOD) begin
      w_rdata[CNT_W-1:0] = r_period_shd;
    end else if (cfg_addr == A_STEP) begin
      w_rdata[CNT_W-1:0] = r_step;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg_addr) == TGT_BASE + i)  w_rdata[CNT_W-1:0] = r_target[i];
      if (int'(cfg_addr) == DUTY_BASE + i) w_rdata[CNT_W-1:0] = r_duty[i];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_enable     <= 1'b0;
      r_cnt        <= '0;
      r_period_act <= DEF_P;
      r_period_shd <= DEF_P;
      r_step       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty[i]   <= '0;
        r_target[i] <= '0;
      end
      r_pwm_p1     <= '0;
      r_tick_p1    <= 1'b0;
      r_busy_p1    <= 1'b0;
      r_rvalid_p1  <= 1'b0;
      r_rdata_p1   <= '0;
`ifdef PWM_RAMP_IRQ_EN
      r_irq_mask   <= 1'b0;
      r_busy_p2    <= 1'b0;
      r_irq_p2     <= 1'b0;
`endif
    end else begin
      r_enable     <= w_en_nxt;
      r_cnt        <= w_cnt_nxt;
      r_period_act <= w_pact_nxt;
      if (cfg_we && cfg_addr == A_PERIOD) r_period_shd <= clamp_period(cfg_wdata[CNT_W-1:0]);
      if (cfg_we && cfg_addr == A_STEP)   r_step       <= cfg_wdata[CNT_W-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wrap) r_duty[i] <= ramp_toward(r_duty[i], r_target[i], r_step);
        if (cfg_we && int'(cfg_addr) == TGT_BASE + i) r_target[i] <= cfg_wdata[CNT_W-1:0];
        r_pwm_p1[i] <= r_enable && (r_cnt < r_duty[i]);
      end
      // Tick is built from next-state so it lines up with cnt==period_act-1.
      r_tick_p1    <= w_en_nxt && (w_cnt_nxt == w_pact_nxt - ONE);
      r_busy_p1    <= w_busy_any;
      r_rvalid_p1  <= cfg_re;
      if (cfg_re) r_rdata_p1 <= w_rdata;
`ifdef PWM_RAMP_IRQ_EN
      if (w_wr_ctrl) r_irq_mask <= cfg_wdata[2];
      r_busy_p2    <= r_busy_p1;
      r_irq_p2     <= r_busy_p2 && !r_busy_p1 && !r_irq_mask;
`endif
    end
  end

  assign cfg_rdata   = r_rdata_p1;
  assign cfg_rvalid  = r_rvalid_p1;
  assign pwm_out     = r_pwm_p1;
  assign period_tick = r_tick_p1;
  assign busy        = r_busy_p1;
`ifdef PWM_RAMP_IRQ_EN
  assign ramp_irq    = r_irq_p2;
`endif

endmodule
